div_unit: RTL and testbench

- Parametrised multi-cycle integer divider for the pipelined core, driven from the EX stage.
- Computes quotient and remainder for signed or unsigned DIV/DIVU with a start/ready handshake; the result feeds the HI/LO write path (HI = remainder, LO = quotient).
- Raises busy_o so the pipeline controller can stall EX while a divide is in flight.
- Generalises the single-cycle EX arithmetic with configurable width, signed-mode enable, divide-by-zero detection and annulment.

---
 rtl/div_unit.sv | 136 +++++++++++++
 tb/tb_div_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring integer divider (DIV/DIVU) for the EX stage.
//   clk          : clock, all state changes on the rising edge
//   rst          : asynchronous reset, active low
//   start_i      : divide request, sampled in FREE, held until ready_o is seen
//   annul_i      : cancel the requested or in-flight divide (pipeline flush)
//   signed_div_i : two's-complement divide (honoured only when SIGNED_EN != 0)
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   result_o     : {remainder, quotient}, feeds HI/LO
//   ready_o      : result valid
//   busy_o       : divide in flight (BY_ZERO or ON), stalls EX
module div_unit #(
  parameter int DATA_W    = 32,
  parameter int SIGNED_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  localparam int   CNT_W = $clog2(DATA_W + 1);
  localparam logic SEN   = (SIGNED_EN != 0);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {ST_FREE, ST_BY_ZERO, ST_ON, ST_END} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   quo_q;     // dividend magnitude, shifted out MSB-first; quotient bits shift in
  logic [DATA_W-1:0]   rem_q;     // partial remainder, always < divisor
  logic [DATA_W-1:0]   dvs_q;     // divisor magnitude
  logic                neg_quo_q; // operand signs differ
  logic                neg_rem_q; // dividend negative
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;

  // operand sign handling at acceptance
  logic              sgn, op1_neg, op2_neg;
  logic [DATA_W-1:0] op1_mag, op2_mag;

  assign sgn     = signed_div_i & SEN;
  assign op1_neg = sgn & opdata1_i[DATA_W-1];
  assign op2_neg = sgn & opdata2_i[DATA_W-1];
  assign op1_mag = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign op2_mag = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

  // one restoring step; DATA_W+1 bits so the borrow shows up in the MSB
  logic [DATA_W:0]   rem_sh, diff;
  logic              qbit;
  logic [DATA_W-1:0] rem_nx, quo_nx, q_fin, r_fin;

  assign rem_sh = {rem_q, quo_q[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign qbit   = ~diff[DATA_W];
  // on restore rem_sh < divisor, so its top bit is zero and dropping it is exact
  assign rem_nx = qbit ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
  assign quo_nx = {quo_q[DATA_W-2:0], qbit};
  // -2^(W-1) / -1 wraps back to -2^(W-1) here, no exception
  assign q_fin  = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
  assign r_fin  = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= ST_BY_ZERO;
            end else begin
              state_q   <= ST_ON;
              quo_q     <= op1_mag;
              dvs_q     <= op2_mag;
              rem_q     <= '0;
              neg_quo_q <= op1_neg ^ op2_neg;
              neg_rem_q <= op1_neg;
              cnt_q     <= '0;
            end
          end
        end
        ST_BY_ZERO: begin
          if (annul_i) begin
            state_q <= ST_FREE;
          end else begin
            state_q  <= ST_END;
            result_q <= '0;
          end
        end
        ST_ON: begin
          if (annul_i) begin
            state_q <= ST_FREE;
          end else begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_q  <= ST_END;
              result_q <= {r_fin, q_fin};
            end
          end
        end
        ST_END: begin
          // ready rises one edge after entering END and falls with the exit edge
          if (!start_i || annul_i) begin
            state_q <= ST_FREE;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_FREE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == ST_ON) || (state_q == ST_BY_ZERO);

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           start_s, start_u, annul, sdiv;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] res_s, res_u;
  logic           rdy_s, rdy_u, bsy_s, bsy_u;

  div_unit #(.DATA_W(W), .SIGNED_EN(1)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_s), .annul_i(annul), .signed_div_i(sdiv),
    .opdata1_i(a), .opdata2_i(b), .result_o(res_s), .ready_o(rdy_s), .busy_o(bsy_s)
  );

  div_unit #(.DATA_W(W), .SIGNED_EN(0)) u_uns (
    .clk(clk), .rst(rst), .start_i(start_u), .annul_i(annul), .signed_div_i(sdiv),
    .opdata1_i(a), .opdata2_i(b), .result_o(res_u), .ready_o(rdy_u), .busy_o(bsy_u)
  );

  int             checks = 0;
  int             errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_exp;
  logic [W-1:0]   rx, ry;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy, q, r;
    if (y == 0) return 64'd0;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'b0, x});
      sy = longint'({32'b0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Drive one divide on the signed (uns=0) or unsigned-only (uns=1) instance,
  // check latency, busy length, result and ready fall after start drops.
  task automatic run_div(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic s, input logic uns);
    int   lat, bcnt;
    logic got;
    logic [63:0] e;
    @(negedge clk);
    a = x; b = y; sdiv = s;
    if (uns) start_u = 1'b1; else start_s = 1'b1;
    exp_q.push_back(model(x, y, s & !uns));
    @(posedge clk); #1;
    // operands are latched at acceptance, so scribbling them must not matter
    a = $urandom; b = $urandom;
    bcnt = (uns ? bsy_u : bsy_s) ? 1 : 0;
    lat  = 0;
    got  = 1'b0;
    for (int n = 1; n <= 60 && !got; n++) begin
      @(posedge clk); #1;
      if (uns ? rdy_u : rdy_s) begin
        got = 1'b1;
        lat = n;
      end else if (uns ? bsy_u : bsy_s) begin
        bcnt++;
      end
    end
    e = exp_q.pop_front();
    chk({tag, " ready"}, 64'(got), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'((y == 0) ? 2 : W + 1));
    chk({tag, " busy cycles"}, 64'(bcnt), 64'((y == 0) ? 1 : W));
    chk({tag, " result"}, uns ? res_u : res_s, e);
    last_exp = e;
    start_s = 1'b0; start_u = 1'b0;
    @(posedge clk); #1;
    chk({tag, " ready fall"}, 64'(uns ? rdy_u : rdy_s), 64'd0);
  endtask

  initial begin
    start_s = 0; start_u = 0; annul = 0; sdiv = 0; a = '0; b = '0;
    last_exp = '0;
    #1;
    chk("reset result", res_s, 64'd0);
    chk("reset ready", 64'(rdy_s), 64'd0);
    chk("reset busy", 64'(bsy_s), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_div("u 100/7", 32'd100, 32'd7, 1'b0, 1'b0);
    chk("u 100/7 const", res_s, {32'd2, 32'd14});
    run_div("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    chk("s -7/2 const", res_s, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("s 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    chk("s 7/-2 const", res_s, {32'h0000_0001, 32'hFFFF_FFFD});
    run_div("div0", 32'h1234, 32'd0, 1'b1, 1'b0);
    run_div("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("s ovf const", res_s, {32'h0, 32'h8000_0000});
    run_div("nosign ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    chk("nosign ovf const", res_u, {32'h8000_0000, 32'h0});

    for (int i = 0; i < 6; i++) begin
      rx = $urandom;
      ry = $urandom >> $urandom_range(0, 28);
      run_div("rand", rx, ry, i[0], 1'b0);
    end

    // annul ten steps into a divide
    @(negedge clk);
    a = 32'd1000; b = 32'd3; sdiv = 1'b0; start_s = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk) annul = 1'b1;
    @(posedge clk); #1;
    chk("annul busy", 64'(bsy_s), 64'd0);
    chk("annul ready", 64'(rdy_s), 64'd0);
    chk("annul result", res_s, last_exp);
    @(negedge clk);
    annul = 1'b0; start_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("annul idle ready", 64'(rdy_s), 64'd0);
    run_div("50/5 after annul", 32'd50, 32'd5, 1'b0, 1'b0);
    chk("50/5 const", res_s, {32'd0, 32'd10});

    // start and annul together in FREE: nothing accepted
    @(negedge clk);
    a = 32'd9; b = 32'd3; start_s = 1'b1; annul = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("start+annul busy", 64'(bsy_s), 64'd0);
    chk("start+annul ready", 64'(rdy_s), 64'd0);
    @(negedge clk);
    start_s = 1'b0; annul = 1'b0;

    // asynchronous reset mid-divide
    @(negedge clk);
    a = 32'd1000; b = 32'd7; start_s = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0; start_s = 1'b0;
    #1;
    chk("async rst result", res_s, 64'd0);
    chk("async rst ready", 64'(rdy_s), 64'd0);
    chk("async rst busy", 64'(bsy_s), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div("after reset", 32'd12345, 32'd67, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
